// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the single-port dmem
// One access slot = one IDLE cycle to sample and register the winner, then one ACCESS cycle.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] ad0,
  input  logic [DW-1:0] wd0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] ad1,
  input  logic [DW-1:0] wd1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          m_wm,
  output logic [AW-1:0] m_ad,
  output logic [DW-1:0] m_in,
  input  logic [DW-1:0] m_out,
  output logic          busy,
  output logic [CW-1:0] tx_cnt
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  logic   last;
  logic   win;
  logic   pick1;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign pick1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      win     <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
      m_wm    <= 1'b0;
      m_ad    <= '0;
      m_in    <= '0;
      busy    <= 1'b0;
      tx_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (req0 | req1) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            last   <= pick1;
            win    <= pick1;
            gnt0   <= ~pick1;
            gnt1   <= pick1;
            m_wm   <= pick1 ? we1 : we0;
            m_ad   <= pick1 ? ad1 : ad0;
            m_in   <= pick1 ? wd1 : wd0;
            tx_cnt <= tx_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ACCESS: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          m_wm  <= 1'b0;
          // m_wm still holds the winner's direction during ACCESS.
          if (!m_wm) begin
            rdata   <= m_out;
            rvalid0 <= ~win;
            rvalid1 <= win;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector table plus randomized run against a transaction-level model
module tb_dmem_arbiter;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, we0, req1, we1;
  logic [7:0] ad0, wd0, ad1, wd1;
  logic gnt0, gnt1, rvalid0, rvalid1, m_wm, busy;
  logic [7:0] rdata, m_ad, m_in, m_out;
  logic [CW-1:0] tx_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .ad0(ad0), .wd0(wd0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .ad1(ad1), .wd1(wd1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .m_wm(m_wm), .m_ad(m_ad), .m_in(m_in), .m_out(m_out),
    .busy(busy), .tx_cnt(tx_cnt)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5C;
  endfunction

  // Behavioural dmem: never reset, unwritten locations read init_val.
  logic [7:0] mem [256];
  logic       wr_flag [256];
  always @(posedge clk) begin
    if (m_wm === 1'b1) begin
      mem[m_ad]     <= m_in;
      wr_flag[m_ad] <= 1'b1;
    end
  end
  assign m_out = (wr_flag[m_ad] === 1'b1) ? mem[m_ad] : init_val(m_ad);

  // Reference: at most one transaction in flight; it finishes on the edge after it was granted.
  logic [7:0]    ref_mem [256];
  bit            fl_v, fl_port, fl_we;
  logic [7:0]    fl_ad, fl_wd;
  bit            m_last;
  logic [CW-1:0] m_cnt;
  logic [7:0]    m_rdata, m_ad_e, m_in_e;
  logic [33:0]   exp_model;

  task automatic model_step();
    bit g0, g1, v0, v1, wm, p;
    g0 = 0; g1 = 0; v0 = 0; v1 = 0; wm = 0;
    if (!rst_n) begin
      if (fl_v && fl_we) ref_mem[fl_ad] = fl_wd;
      fl_v = 0; m_last = 1; m_cnt = '0; m_rdata = 0; m_ad_e = 0; m_in_e = 0;
    end else if (fl_v) begin
      if (fl_we) ref_mem[fl_ad] = fl_wd;
      else begin
        m_rdata = ref_mem[fl_ad];
        if (fl_port) v1 = 1; else v0 = 1;
      end
      fl_v = 0;
    end else if (req0 || req1) begin
      p = (req0 && req1) ? !m_last : req1;
      fl_v = 1; fl_port = p; m_last = p; m_cnt = m_cnt + 1'b1;
      fl_we = p ? we1 : we0;
      fl_ad = p ? ad1 : ad0;
      fl_wd = p ? wd1 : wd0;
      wm = fl_we; m_ad_e = fl_ad; m_in_e = fl_wd;
      if (p) g1 = 1; else g0 = 1;
    end
    exp_model = {g0, g1, v0, v1, m_rdata, wm, m_ad_e, m_in_e, fl_v, m_cnt};
  endtask

  typedef struct {
    logic rst, r0, w0; logic [7:0] a0, d0;
    logic r1, w1;      logic [7:0] a1, d1;
    logic [33:0] exp;
  } vec_t;

  function automatic vec_t mk(input int rst, r0, w0, a0, d0, r1, w1, a1, d1,
                              g0, g1, v0, v1, rd, wm, ma, mi, bsy, tx);
    vec_t v;
    v.rst = rst[0]; v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[7:0]; v.d0 = d0[7:0];
    v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[7:0]; v.d1 = d1[7:0];
    v.exp = {g0[0], g1[0], v0[0], v1[0], rd[7:0], wm[0], ma[7:0], mi[7:0], bsy[0], tx[CW-1:0]};
    return v;
  endfunction

  function automatic logic [33:0] actual();
    return {gnt0, gnt1, rvalid0, rvalid1, rdata, m_wm, m_ad, m_in, busy, tx_cnt};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (g0 g1 v0 v1 rdata wm ad in busy tx)", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, r0, w0, input logic [7:0] a0, d0,
                       input logic r1, w1, input logic [7:0] a1, d1);
    rst_n = rst; req0 = r0; we0 = w0; ad0 = a0; wd0 = d0;
    req1 = r1; we1 = w1; ad1 = a1; wd1 = d1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [27];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
    fl_v = 0; m_last = 1; m_cnt = '0; m_rdata = 0; m_ad_e = 0; m_in_e = 0;

    // reset with req0 held, then write/read port 0
    vecs[0]  = mk(0,1,0,0,0,    0,0,0,0,     0,0,0,0,0,0,0,0,0,0);
    vecs[1]  = mk(0,1,0,0,0,    0,0,0,0,     0,0,0,0,0,0,0,0,0,0);
    vecs[2]  = mk(1,1,1,3,3,    0,0,0,0,     1,0,0,0,0,1,3,3,1,1);
    vecs[3]  = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,0,0,0,3,3,0,1);
    vecs[4]  = mk(1,1,0,3,0,    0,0,0,0,     1,0,0,0,0,0,3,0,1,2);
    vecs[5]  = mk(1,0,0,0,0,    0,0,0,0,     0,0,1,0,3,0,3,0,0,2);
    vecs[6]  = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,0,3,0,3,0,0,2);
    // unwritten read on port 1
    vecs[7]  = mk(1,0,0,0,0,    1,0,2,0,     0,1,0,0,3,0,2,0,1,3);
    vecs[8]  = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,1,'h5E,0,2,0,0,3);
    vecs[9]  = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,0,'h5E,0,2,0,0,3);
    // continuous contention, reads
    vecs[10] = mk(1,1,0,'h10,0, 1,0,'h11,0,  1,0,0,0,'h5E,0,'h10,0,1,4);
    vecs[11] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,0,1,0,'h4C,0,'h10,0,0,4);
    vecs[12] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,1,0,0,'h4C,0,'h11,0,1,5);
    vecs[13] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,0,0,1,'h4D,0,'h11,0,0,5);
    vecs[14] = mk(1,1,0,'h10,0, 1,0,'h11,0,  1,0,0,0,'h4D,0,'h10,0,1,6);
    vecs[15] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,0,1,0,'h4C,0,'h10,0,0,6);
    vecs[16] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,1,0,0,'h4C,0,'h11,0,1,7);
    vecs[17] = mk(1,1,0,'h10,0, 1,0,'h11,0,  0,0,0,1,'h4D,0,'h11,0,0,7);
    // write on port 0 then read of same address on port 1
    vecs[18] = mk(1,1,1,5,'hA5, 1,0,5,0,     1,0,0,0,'h4D,1,5,'hA5,1,8);
    vecs[19] = mk(1,0,0,0,0,    1,0,5,0,     0,0,0,0,'h4D,0,5,'hA5,0,8);
    vecs[20] = mk(1,0,0,0,0,    1,0,5,0,     0,1,0,0,'h4D,0,5,0,1,9);
    vecs[21] = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,1,'hA5,0,5,0,0,9);
    // reset at the edge ending a write; the write still lands
    vecs[22] = mk(1,1,1,7,'h5A, 0,0,0,0,     1,0,0,0,'hA5,1,7,'h5A,1,10);
    vecs[23] = mk(0,0,0,0,0,    0,0,0,0,     0,0,0,0,0,0,0,0,0,0);
    vecs[24] = mk(1,1,0,7,0,    0,0,0,0,     1,0,0,0,0,0,7,0,1,1);
    vecs[25] = mk(1,0,0,0,0,    0,0,0,0,     0,0,1,0,'h5A,0,7,0,0,1);
    vecs[26] = mk(1,0,0,0,0,    0,0,0,0,     0,0,0,0,'h5A,0,7,0,0,1);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // randomized traffic with occasional resets; tx_cnt wraps several times
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 15)), 8'($urandom));
      check($sformatf("rand%0d", i), actual(), exp_model);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
